biriscv_issue_sched: RTL and testbench



---
 rtl/biriscv_issue_sched_pkg.sv | 34 +++
 rtl/biriscv_issue_sched_scoreboard.sv | 25 ++
 rtl/biriscv_issue_sched.sv | 79 +++++++
 tb/tb_biriscv_issue_sched.sv | 127 ++++++++++++
 4 files changed

// File: rtl/biriscv_issue_sched_pkg.sv
// biriscv_issue_sched_pkg: opcode field layout, major opcodes and issue-class bit positions
package biriscv_issue_sched_pkg;
  localparam int RD_LSB = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam int CLS_EXEC = 0;
  localparam int CLS_LSU = 1;
  localparam int CLS_BR = 2;
  localparam int CLS_MUL = 3;
  localparam int CLS_DIV = 4;
  localparam int CLS_CSR = 5;
  localparam int CLS_RDV = 6;
  localparam int CLS_W = 7;
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic use_rs2;
  } regs_t;
  function automatic regs_t decode_regs(input logic [31:0] op);
    regs_t r;
    r.rd = op[RD_LSB +: 5];
    r.rs1 = op[RS1_LSB +: 5];
    r.rs2 = op[RS2_LSB +: 5];
    r.use_rs2 = (op[6:0] == OPC_R) || (op[6:0] == OPC_S) || (op[6:0] == OPC_B);
    return r;
  endfunction
  function automatic logic cls(input logic [CLS_W-1:0] c, input int b);
    return c[b];
  endfunction
endpackage

// File: rtl/biriscv_issue_sched_scoreboard.sv
// biriscv_issue_sched_scoreboard: 32-entry pending-writeback bitmap with set/clear and six lookups
module biriscv_issue_sched_scoreboard (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            set_i,
  input  logic [4:0]      set_rd_i,
  input  logic            clr_i,
  input  logic [4:0]      clr_rd_i,
  input  logic [5:0][4:0] idx_i,
  output logic [5:0]      hit_o,
  output logic            any_o
);
  logic [31:0] sb_q, sb_d;
  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_rd_i] = 1'b0;
    if (set_i) sb_d[set_rd_i] = 1'b1;
  end
  always_ff @(posedge clk_i)
    sb_q <= rst_i ? '0 : sb_d;
  for (genvar i = 0; i < 6; i++) begin : g_lk
    assign hit_o[i] = sb_q[idx_i[i]];
  end
  assign any_o = |sb_q;
endmodule

// File: rtl/biriscv_issue_sched.sv
// biriscv_issue_sched: dual-issue decision from register hazards, structural limits and the scoreboard
module biriscv_issue_sched
  import biriscv_issue_sched_pkg::*;
#(
  parameter bit SUPPORT_DUAL_ISSUE = 1'b1,
  parameter bit SUPPORT_MUL_PIPE1 = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slot0_valid_i,
  input  logic [31:0] slot0_opcode_i,
  input  logic        slot0_exec_i,
  input  logic        slot0_lsu_i,
  input  logic        slot0_branch_i,
  input  logic        slot0_mul_i,
  input  logic        slot0_div_i,
  input  logic        slot0_csr_i,
  input  logic        slot0_rd_valid_i,
  input  logic        slot1_valid_i,
  input  logic [31:0] slot1_opcode_i,
  input  logic        slot1_exec_i,
  input  logic        slot1_lsu_i,
  input  logic        slot1_branch_i,
  input  logic        slot1_mul_i,
  input  logic        slot1_div_i,
  input  logic        slot1_csr_i,
  input  logic        slot1_rd_valid_i,
  input  logic        issue_ready_i,
  input  logic        squash_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        div_complete_i,
  output logic        issue0_valid_o,
  output logic        issue1_valid_o,
  output logic        div_busy_o,
  output logic        sb_busy_o
);
  regs_t r0, r1;
  logic [CLS_W-1:0] c0, c1;
  logic [5:0] hit;
  logic sb_any, sb_set, haz0, haz1, rd0v, raw1, waw1;
  logic div_busy_q, div_busy_d;
  assign r0 = decode_regs(slot0_opcode_i);
  assign r1 = decode_regs(slot1_opcode_i);
  assign c0 = {slot0_rd_valid_i, slot0_csr_i, slot0_div_i, slot0_mul_i, slot0_branch_i, slot0_lsu_i, slot0_exec_i};
  assign c1 = {slot1_rd_valid_i, slot1_csr_i, slot1_div_i, slot1_mul_i, slot1_branch_i, slot1_lsu_i, slot1_exec_i};
  biriscv_issue_sched_scoreboard u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_i    (sb_set),
    .set_rd_i (r0.rd),
    .clr_i    (wb_valid_i && wb_rd_i != 5'd0),
    .clr_rd_i (wb_rd_i),
    .idx_i    ({r1.rd, r1.rs2, r1.rs1, r0.rd, r0.rs2, r0.rs1}),
    .hit_o    (hit),
    .any_o    (sb_any)
  );
  always_comb begin
    haz0 = (hit[0] && r0.rs1 != 5'd0) || (hit[1] && r0.use_rs2 && r0.rs2 != 5'd0) ||
           (hit[2] && cls(c0, CLS_RDV) && r0.rd != 5'd0);
    haz1 = (hit[3] && r1.rs1 != 5'd0) || (hit[4] && r1.use_rs2 && r1.rs2 != 5'd0) ||
           (hit[5] && cls(c1, CLS_RDV) && r1.rd != 5'd0);
    issue0_valid_o = !rst_i && slot0_valid_i && issue_ready_i && !squash_i && !haz0 &&
                     !(cls(c0, CLS_DIV) && div_busy_q) && !(cls(c0, CLS_CSR) && (sb_any || div_busy_q));
    rd0v = cls(c0, CLS_RDV) && r0.rd != 5'd0;
    raw1 = rd0v && (r1.rs1 == r0.rd || (r1.use_rs2 && r1.rs2 == r0.rd));
    waw1 = cls(c0, CLS_RDV) && cls(c1, CLS_RDV) && r1.rd == r0.rd;
    issue1_valid_o = SUPPORT_DUAL_ISSUE && slot1_valid_i && issue0_valid_o &&
                     !cls(c0, CLS_BR) && !cls(c0, CLS_CSR) &&
                     (cls(c1, CLS_EXEC) || (SUPPORT_MUL_PIPE1 && cls(c1, CLS_MUL))) &&
                     !(cls(c1, CLS_MUL) && cls(c0, CLS_MUL)) && !raw1 && !waw1 && !haz1;
    sb_set = issue0_valid_o && ((cls(c0, CLS_LSU) && cls(c0, CLS_RDV)) || cls(c0, CLS_DIV)) && r0.rd != 5'd0;
    div_busy_d = (issue0_valid_o && cls(c0, CLS_DIV)) || (div_busy_q && !div_complete_i);
  end
  always_ff @(posedge clk_i)
    div_busy_q <= rst_i ? 1'b0 : div_busy_d;
  assign div_busy_o = div_busy_q;
  assign sb_busy_o = sb_any;
endmodule

// File: tb/tb_biriscv_issue_sched.sv
// tb_biriscv_issue_sched: table vectors plus multi-cycle hazard sequences checked through an expectation queue
module tb_biriscv_issue_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic v0, v1, rdy, sq, wbv, dc;
  logic [31:0] op0, op1;
  logic [6:0] f0, f1;
  logic [4:0] wbrd;
  logic i0, i1, db, sbb;
  int n_vec = 0, n_bad = 0;
  localparam logic [6:0] F_ALU = 7'b1000001, F_LD = 7'b1000010, F_ST = 7'b0000010, F_BR = 7'b0000100,
                         F_MUL = 7'b1001000, F_DIV = 7'b1010000, F_CSR = 7'b1100000;
  always #5 clk = ~clk;
  biriscv_issue_sched dut (
    .clk_i(clk), .rst_i(rst),
    .slot0_valid_i(v0), .slot0_opcode_i(op0),
    .slot0_exec_i(f0[0]), .slot0_lsu_i(f0[1]), .slot0_branch_i(f0[2]), .slot0_mul_i(f0[3]),
    .slot0_div_i(f0[4]), .slot0_csr_i(f0[5]), .slot0_rd_valid_i(f0[6]),
    .slot1_valid_i(v1), .slot1_opcode_i(op1),
    .slot1_exec_i(f1[0]), .slot1_lsu_i(f1[1]), .slot1_branch_i(f1[2]), .slot1_mul_i(f1[3]),
    .slot1_div_i(f1[4]), .slot1_csr_i(f1[5]), .slot1_rd_valid_i(f1[6]),
    .issue_ready_i(rdy), .squash_i(sq), .wb_valid_i(wbv), .wb_rd_i(wbrd), .div_complete_i(dc),
    .issue0_valid_o(i0), .issue1_valid_o(i1), .div_busy_o(db), .sb_busy_o(sbb)
  );
  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, rs1, rs2); return rtype(7'h00, rd, rs1, rs2, 3'd0); endfunction
  function automatic logic [31:0] sub(input logic [4:0] rd, rs1, rs2); return rtype(7'h20, rd, rs1, rs2, 3'd0); endfunction
  function automatic logic [31:0] mul(input logic [4:0] rd, rs1, rs2); return rtype(7'h01, rd, rs1, rs2, 3'd0); endfunction
  function automatic logic [31:0] div(input logic [4:0] rd, rs1, rs2); return rtype(7'h01, rd, rs1, rs2, 3'd4); endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs1); return {12'd0, rs1, 3'b010, rd, 7'b0000011}; endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [11:0] imm); return {imm, rs1, 3'b000, rd, 7'b0010011}; endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, rs1); return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011}; endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1, rs2); return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011}; endfunction
  function automatic logic [31:0] csrrw(input logic [4:0] rd, rs1); return {12'h340, rs1, 3'b001, rd, 7'b1110011}; endfunction
  typedef struct { logic [3:0] e; string nm; } exp_t;
  exp_t q[$];
  typedef struct {
    logic v0; logic [31:0] op0; logic [6:0] f0;
    logic v1; logic [31:0] op1; logic [6:0] f1;
    logic rdy, sq, e0, e1; string nm;
  } vec_t;
  vec_t tv[16];
  task automatic s0(input logic v, input logic [31:0] op, input logic [6:0] f); v0 = v; op0 = op; f0 = f; endtask
  task automatic s1(input logic v, input logic [31:0] op, input logic [6:0] f); v1 = v; op1 = op; f1 = f; endtask
  task automatic idle();
    s0(1'b0, 32'd0, 7'd0); s1(1'b0, 32'd0, 7'd0);
    rdy = 1'b1; sq = 1'b0; wbv = 1'b0; wbrd = 5'd0; dc = 1'b0;
  endtask
  task automatic step(input logic e0, e1, edb, esb, input string nm);
    exp_t x;
    q.push_back('{{e0, e1, edb, esb}, nm});
    @(negedge clk);
    x = q.pop_front();
    n_vec++;
    if ({i0, i1, db, sbb} !== x.e) begin
      n_bad++;
      $display("FAIL %s: {i0,i1,div_busy,sb_busy} got %b want %b", x.nm, {i0, i1, db, sbb}, x.e);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{1, add(1, 2, 3), F_ALU, 1, add(4, 5, 6), F_ALU, 1, 0, 1, 1, "dual_add"};
    tv[1]  = '{1, add(1, 2, 3), F_ALU, 1, add(4, 5, 6), F_ALU, 0, 0, 0, 0, "not_ready"};
    tv[2]  = '{1, add(1, 2, 3), F_ALU, 1, add(4, 5, 6), F_ALU, 1, 1, 0, 0, "squash"};
    tv[3]  = '{0, add(1, 2, 3), F_ALU, 1, add(4, 5, 6), F_ALU, 1, 0, 0, 0, "slot0_empty"};
    tv[4]  = '{1, add(3, 1, 2), F_ALU, 1, sub(4, 3, 1), F_ALU, 1, 0, 1, 0, "raw_rs1"};
    tv[5]  = '{1, add(3, 1, 2), F_ALU, 1, add(4, 1, 3), F_ALU, 1, 0, 1, 0, "raw_rs2"};
    tv[6]  = '{1, add(3, 1, 2), F_ALU, 1, add(3, 5, 6), F_ALU, 1, 0, 1, 0, "waw"};
    tv[7]  = '{1, mul(1, 2, 3), F_MUL, 1, mul(4, 5, 6), F_MUL, 1, 0, 1, 0, "two_mul"};
    tv[8]  = '{1, add(1, 2, 3), F_ALU, 1, mul(4, 5, 6), F_MUL, 1, 0, 1, 1, "mul_pipe1"};
    tv[9]  = '{1, beq(1, 2), F_BR, 1, add(4, 5, 6), F_ALU, 1, 0, 1, 0, "behind_branch"};
    tv[10] = '{1, csrrw(10, 9), F_CSR, 1, add(4, 5, 6), F_ALU, 1, 0, 1, 0, "behind_csr"};
    tv[11] = '{1, add(1, 2, 3), F_ALU, 1, lw(5, 2), F_LD, 1, 0, 1, 0, "slot1_lsu"};
    tv[12] = '{1, add(0, 1, 2), F_ALU, 1, add(4, 0, 0), F_ALU, 1, 0, 1, 1, "rd_x0"};
    tv[13] = '{1, add(3, 1, 2), F_ALU, 1, addi(4, 1, 12'd3), F_ALU, 1, 0, 1, 1, "itype_no_rs2"};
    tv[14] = '{1, sw(2, 1), F_ST, 1, add(4, 5, 6), F_ALU, 1, 0, 1, 1, "store_dual"};
    tv[15] = '{1, add(1, 2, 3), F_ALU, 0, add(4, 5, 6), F_ALU, 1, 0, 1, 0, "slot1_empty"};
    idle();
    rst = 1'b1;
    s0(1'b1, add(1, 2, 3), F_ALU); s1(1'b1, add(4, 5, 6), F_ALU);
    step(0, 0, 0, 0, "in_reset");
    step(0, 0, 0, 0, "in_reset2");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s0(tv[i].v0, tv[i].op0, tv[i].f0); s1(tv[i].v1, tv[i].op1, tv[i].f1);
      rdy = tv[i].rdy; sq = tv[i].sq;
      step(tv[i].e0, tv[i].e1, 1'b0, 1'b0, tv[i].nm);
    end
    idle();
    s0(1, lw(5, 1), F_LD);           step(1, 0, 0, 0, "lw_issue");
    s0(1, add(6, 5, 7), F_ALU);      step(0, 0, 0, 1, "lw_use_held");
    s0(1, add(1, 2, 3), F_ALU); s1(1, add(6, 5, 7), F_ALU); step(1, 0, 0, 1, "slot1_sb_hazard");
    s1(0, 0, 0);
    s0(1, add(6, 5, 7), F_ALU); wbv = 1; wbrd = 5; step(0, 0, 0, 1, "no_wb_bypass");
    wbv = 0;                         step(1, 0, 0, 0, "lw_use_issue");
    idle();
    s0(1, div(8, 1, 2), F_DIV);      step(1, 0, 0, 0, "div_issue");
    s0(1, div(9, 3, 4), F_DIV);      step(0, 0, 1, 1, "div_held");
    dc = 1;                          step(0, 0, 1, 1, "div_held_complete");
    dc = 0;                          step(1, 0, 0, 1, "div2_issue");
    idle(); dc = 1; wbv = 1; wbrd = 8; step(0, 0, 1, 1, "div2_busy");
    dc = 0; wbrd = 9;                step(0, 0, 0, 1, "div_done");
    idle();                          step(0, 0, 0, 0, "div_wb_clear");
    s0(1, div(0, 1, 2), F_DIV); dc = 1; step(1, 0, 0, 0, "div_set_vs_clr");
    idle();                          step(0, 0, 1, 0, "div_set_wins");
    dc = 1; wbv = 1; wbrd = 12;      step(0, 0, 1, 0, "wb_clear_noop");
    idle();                          step(0, 0, 0, 0, "idle");
    s0(1, lw(9, 1), F_LD);           step(1, 0, 0, 0, "lw9_issue");
    s0(1, csrrw(10, 1), F_CSR); s1(1, add(4, 5, 6), F_ALU); step(0, 0, 0, 1, "csr_serialise");
    s0(1, add(1, 2, 3), F_ALU); sq = 1; step(0, 0, 0, 1, "squash_sb");
    sq = 0; s0(1, csrrw(10, 1), F_CSR); wbv = 1; wbrd = 9; step(0, 0, 0, 1, "csr_wb_same");
    wbv = 0;                         step(1, 0, 0, 0, "csr_issue");
    idle();
    s0(1, lw(5, 1), F_LD);           step(1, 0, 0, 0, "rst_lw5");
    s0(1, lw(9, 1), F_LD);           step(1, 0, 0, 1, "rst_lw9");
    s0(1, div(0, 1, 2), F_DIV);      step(1, 0, 0, 1, "rst_div");
    idle();                          step(0, 0, 1, 1, "pre_reset");
    rst = 1; s0(1, add(1, 2, 3), F_ALU); step(0, 0, 1, 1, "reset_forces_idle");
    rst = 0; s0(1, add(6, 5, 7), F_ALU); step(1, 0, 0, 0, "post_reset_clear");
    idle(); wbv = 1; wbrd = 5;       step(0, 0, 0, 0, "post_reset_wb");
    idle();                          step(0, 0, 0, 0, "final_idle");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
